mc_control_fsm: RTL and testbench

- Multicycle control unit for the CPU datapath; drives the ALU interface.
- Decodes the 6-bit opcode held in IR and sequences FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK.
- Produces ALU_selection and the datapath mux selects and write enables.
- Consumes the ALU's Beq_alu flag to resolve BEQ, and handshakes with the unified memory through mem_ready.

---
 rtl/mc_control_fsm_if.sv | 40 ++++
 rtl/mc_control_fsm.sv | 192 +++++++++++++++++++
 tb/tb_mc_control_fsm.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mc_control_fsm_if.sv
// Control bus between the multicycle controller and the CPU datapath.
// The controller (master) drives the selects and enables; the datapath returns IR opcode, ALU flag and memory ready.
interface mc_control_fsm_if;
    logic [5:0] opcode;
    logic       Beq_alu;
    logic       mem_ready;
    logic [3:0] ALU_selection;
    logic       ALU_srcA;
    logic [1:0] ALU_srcB;
    logic       PC_write;
    logic [1:0] PC_src;
    logic       IR_write;
    logic       Mem_read;
    logic       Mem_write;
    logic       IorD;
    logic       Reg_write;
    logic       RegDst;
    logic       MemtoReg;
    logic       illegal_op;
    logic       mem_timeout;
    logic [3:0] state;

    modport master (
        input  opcode, Beq_alu, mem_ready,
        output ALU_selection, ALU_srcA, ALU_srcB,
        output PC_write, PC_src, IR_write,
        output Mem_read, Mem_write, IorD,
        output Reg_write, RegDst, MemtoReg,
        output illegal_op, mem_timeout, state
    );

    modport slave (
        output opcode, Beq_alu, mem_ready,
        input  ALU_selection, ALU_srcA, ALU_srcB,
        input  PC_write, PC_src, IR_write,
        input  Mem_read, Mem_write, IorD,
        input  Reg_write, RegDst, MemtoReg,
        input  illegal_op, mem_timeout, state
    );
endinterface

// File: rtl/mc_control_fsm.sv
// Multicycle CPU control unit: sequences fetch/decode/execute/memory/writeback.
// Moore decode from state and latched opcode; only memory-ready and branch-flag gate enables directly.
module mc_control_fsm #(
    parameter int MAX_WAIT = 255,
    parameter int WAIT_W   = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    mc_control_fsm_if.master  bus
);

    typedef enum logic [3:0] {
        S_RST    = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_EXEC   = 4'd3,
        S_ALUWB  = 4'd4,
        S_MADDR  = 4'd5,
        S_MRD    = 4'd6,
        S_MWB    = 4'd7,
        S_MWR    = 4'd8,
        S_BRANCH = 4'd9,
        S_JUMP   = 4'd10
    } state_t;

    localparam logic [WAIT_W-1:0] LAST = WAIT_W'(MAX_WAIT - 1);

    state_t            st;
    logic [5:0]        op_q;
    logic [WAIT_W-1:0] wait_cnt;
    logic              timeout_q;

    logic alu_nib_ok;
    logic is_alu;
    logic is_mem;
    logic is_beq;
    logic is_j;
    logic expired;
    logic imm_q;

    // Classify the live opcode; only consulted while in DECODE.
    always_comb begin
        alu_nib_ok = 1'b0;
        case (bus.opcode[3:0])
            4'h0, 4'h1, 4'h2, 4'h3,
            4'h4, 4'h5, 4'h7, 4'h9: alu_nib_ok = 1'b1;
            default:                alu_nib_ok = 1'b0;
        endcase
        is_alu = alu_nib_ok && !bus.opcode[4];
        is_alu = is_alu && (bus.opcode[5:4] != 2'b11);
        is_mem = (bus.opcode[5:1] == 5'b01000);
        is_beq = (bus.opcode == 6'b010010);
        is_j   = (bus.opcode == 6'b010011);
    end

    assign expired = !bus.mem_ready && (wait_cnt == LAST);
    assign imm_q   = (op_q[5:4] == 2'b10);

    // State, latched opcode, memory wait counter and sticky timeout flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st        <= S_RST;
            op_q      <= '0;
            wait_cnt  <= '0;
            timeout_q <= 1'b0;
        end else begin
            wait_cnt <= '0;
            case (st)
                S_RST: st <= S_FETCH;
                S_FETCH: begin
                    if (bus.mem_ready) begin
                        st <= S_DECODE;
                    end else if (expired) begin
                        timeout_q <= 1'b1;
                        st        <= S_FETCH;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                S_DECODE: begin
                    op_q <= bus.opcode;
                    unique case (1'b1)
                        is_alu:  st <= S_EXEC;
                        is_mem:  st <= S_MADDR;
                        is_beq:  st <= S_BRANCH;
                        is_j:    st <= S_JUMP;
                        default: st <= S_FETCH;
                    endcase
                end
                S_EXEC:  st <= S_ALUWB;
                S_ALUWB: st <= S_FETCH;
                S_MADDR: st <= op_q[0] ? S_MWR : S_MRD;
                S_MRD: begin
                    if (bus.mem_ready) begin
                        st <= S_MWB;
                    end else if (expired) begin
                        timeout_q <= 1'b1;
                        st        <= S_FETCH;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                S_MWB: st <= S_FETCH;
                S_MWR: begin
                    if (bus.mem_ready) begin
                        st <= S_FETCH;
                    end else if (expired) begin
                        timeout_q <= 1'b1;
                        st        <= S_FETCH;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                S_BRANCH: st <= S_FETCH;
                S_JUMP:   st <= S_FETCH;
                default:  st <= S_RST;
            endcase
        end
    end

    // Datapath controls decoded from the current state and latched opcode.
    always_comb begin
        bus.ALU_selection = 4'b0000;
        bus.ALU_srcA      = 1'b0;
        bus.ALU_srcB      = 2'b00;
        bus.PC_write      = 1'b0;
        bus.PC_src        = 2'b00;
        bus.IR_write      = 1'b0;
        bus.Mem_read      = 1'b0;
        bus.Mem_write     = 1'b0;
        bus.IorD          = 1'b0;
        bus.Reg_write     = 1'b0;
        bus.RegDst        = 1'b0;
        bus.MemtoReg      = 1'b0;
        bus.illegal_op    = 1'b0;
        case (st)
            S_FETCH: begin
                bus.Mem_read      = 1'b1;
                bus.ALU_selection = 4'b0010;
                bus.ALU_srcB      = 2'b01;
                bus.IR_write      = bus.mem_ready;
                bus.PC_write      = bus.mem_ready;
            end
            S_DECODE: begin
                bus.ALU_selection = 4'b0010;
                bus.ALU_srcB      = 2'b11;
                bus.illegal_op    = !(is_alu || is_mem || is_beq || is_j);
            end
            S_EXEC: begin
                bus.ALU_selection = op_q[3:0];
                bus.ALU_srcA      = 1'b1;
                bus.ALU_srcB      = imm_q ? 2'b10 : 2'b00;
            end
            S_ALUWB: begin
                bus.Reg_write = 1'b1;
                bus.RegDst    = !imm_q;
            end
            S_MADDR: begin
                bus.ALU_selection = 4'b0010;
                bus.ALU_srcA      = 1'b1;
                bus.ALU_srcB      = 2'b10;
            end
            S_MRD: begin
                bus.Mem_read = 1'b1;
                bus.IorD     = 1'b1;
            end
            S_MWB: begin
                bus.Reg_write = 1'b1;
                bus.MemtoReg  = 1'b1;
            end
            S_MWR: begin
                bus.Mem_write = 1'b1;
                bus.IorD      = 1'b1;
            end
            S_BRANCH: begin
                bus.ALU_selection = 4'b0011;
                bus.ALU_srcA      = 1'b1;
                bus.PC_src        = 2'b01;
                bus.PC_write      = bus.Beq_alu;
            end
            S_JUMP: begin
                bus.PC_src   = 2'b10;
                bus.PC_write = 1'b1;
            end
            default: ;
        endcase
    end

    assign bus.mem_timeout = timeout_q;
    assign bus.state       = st;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Directed bench for the multicycle controller.
// Walks each instruction class, memory waits, illegal opcodes, timeout and async reset.
module tb_mc_control_fsm;

    localparam logic [7:0] ST_RST    = 8'd0;
    localparam logic [7:0] ST_FETCH  = 8'd1;
    localparam logic [7:0] ST_DECODE = 8'd2;
    localparam logic [7:0] ST_EXEC   = 8'd3;
    localparam logic [7:0] ST_ALUWB  = 8'd4;
    localparam logic [7:0] ST_MADDR  = 8'd5;
    localparam logic [7:0] ST_MRD    = 8'd6;
    localparam logic [7:0] ST_MWB    = 8'd7;
    localparam logic [7:0] ST_MWR    = 8'd8;
    localparam logic [7:0] ST_BRANCH = 8'd9;
    localparam logic [7:0] ST_JUMP   = 8'd10;

    logic clk;
    logic rst_n;
    int   passes;
    int   total;

    mc_control_fsm_if bus ();

    mc_control_fsm #(
        .MAX_WAIT (4),
        .WAIT_W   (8)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Free-running 10-unit clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [7:0] got,
                       input logic [7:0] exp);
        total++;
        assert (got === exp) passes++;
        else $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic all_idle(input string tag);
        logic [7:0] v;
        v = {bus.PC_write, bus.IR_write, bus.Mem_read, bus.Mem_write,
             bus.Reg_write, bus.illegal_op, bus.IorD, bus.MemtoReg};
        chk({tag, "_en"}, v, 8'h00);
        chk({tag, "_alu"}, 8'(bus.ALU_selection), 8'h0);
        v = {2'b00, bus.ALU_srcA, bus.ALU_srcB, bus.PC_src, bus.RegDst};
        chk({tag, "_sel"}, v, 8'h00);
    endtask

    initial begin
        passes        = 0;
        total         = 0;
        rst_n         = 1'b0;
        bus.opcode    = 6'b000010;
        bus.Beq_alu   = 1'b0;
        bus.mem_ready = 1'b1;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_state", bus.state, ST_RST);
        all_idle("rst");
        chk("rst_tmo", 8'(bus.mem_timeout), 8'h0);
        rst_n = 1'b1;
        #1;
        chk("rel_state", bus.state, ST_RST);

        // ADD, zero-wait memory
        tick;
        chk("add_f_st", bus.state, ST_FETCH);
        chk("add_f_irw", 8'(bus.IR_write), 8'h1);
        chk("add_f_pcw", 8'(bus.PC_write), 8'h1);
        chk("add_f_alu", 8'(bus.ALU_selection), 8'h2);
        chk("add_f_srcb", 8'(bus.ALU_srcB), 8'h1);
        chk("add_f_mrd", 8'(bus.Mem_read), 8'h1);
        chk("add_f_iord", 8'(bus.IorD), 8'h0);
        tick;
        chk("add_d_st", bus.state, ST_DECODE);
        chk("add_d_srcb", 8'(bus.ALU_srcB), 8'h3);
        chk("add_d_ill", 8'(bus.illegal_op), 8'h0);
        chk("add_d_irw", 8'(bus.IR_write), 8'h0);
        tick;
        chk("add_e_st", bus.state, ST_EXEC);
        chk("add_e_alu", 8'(bus.ALU_selection), 8'h2);
        chk("add_e_srca", 8'(bus.ALU_srcA), 8'h1);
        chk("add_e_srcb", 8'(bus.ALU_srcB), 8'h0);
        tick;
        chk("add_w_st", bus.state, ST_ALUWB);
        chk("add_w_rw", 8'(bus.Reg_write), 8'h1);
        chk("add_w_dst", 8'(bus.RegDst), 8'h1);
        chk("add_w_m2r", 8'(bus.MemtoReg), 8'h0);
        tick;
        chk("add_back_f", bus.state, ST_FETCH);

        // ADDI
        bus.opcode = 6'b100010;
        tick;
        tick;
        chk("addi_e_st", bus.state, ST_EXEC);
        chk("addi_e_alu", 8'(bus.ALU_selection), 8'h2);
        chk("addi_e_srcb", 8'(bus.ALU_srcB), 8'h2);
        tick;
        chk("addi_w_rw", 8'(bus.Reg_write), 8'h1);
        chk("addi_w_dst", 8'(bus.RegDst), 8'h0);
        tick;
        chk("addi_back_f", bus.state, ST_FETCH);

        // LI (pass B, immediate)
        bus.opcode = 6'b101001;
        tick;
        tick;
        chk("li_e_alu", 8'(bus.ALU_selection), 8'h9);
        chk("li_e_srcb", 8'(bus.ALU_srcB), 8'h2);
        tick;
        chk("li_w_dst", 8'(bus.RegDst), 8'h0);
        tick;

        // LW with 3 wait cycles in MRD
        bus.opcode = 6'b010000;
        tick;
        tick;
        chk("lw_a_st", bus.state, ST_MADDR);
        chk("lw_a_alu", 8'(bus.ALU_selection), 8'h2);
        chk("lw_a_srca", 8'(bus.ALU_srcA), 8'h1);
        chk("lw_a_srcb", 8'(bus.ALU_srcB), 8'h2);
        bus.mem_ready = 1'b0;
        tick;
        chk("lw_r1_st", bus.state, ST_MRD);
        chk("lw_r1_mrd", 8'(bus.Mem_read), 8'h1);
        chk("lw_r1_iord", 8'(bus.IorD), 8'h1);
        tick;
        chk("lw_r2_mrd", 8'(bus.Mem_read), 8'h1);
        tick;
        chk("lw_r3_mrd", 8'(bus.Mem_read), 8'h1);
        tick;
        chk("lw_r4_st", bus.state, ST_MRD);
        chk("lw_r4_mrd", 8'(bus.Mem_read), 8'h1);
        bus.mem_ready = 1'b1;
        tick;
        chk("lw_wb_st", bus.state, ST_MWB);
        chk("lw_wb_rw", 8'(bus.Reg_write), 8'h1);
        chk("lw_wb_m2r", 8'(bus.MemtoReg), 8'h1);
        chk("lw_wb_dst", 8'(bus.RegDst), 8'h0);
        chk("lw_no_tmo", 8'(bus.mem_timeout), 8'h0);
        tick;
        chk("lw_back_f", bus.state, ST_FETCH);

        // BEQ taken
        bus.opcode  = 6'b010010;
        bus.Beq_alu = 1'b1;
        tick;
        tick;
        chk("beq1_st", bus.state, ST_BRANCH);
        chk("beq1_alu", 8'(bus.ALU_selection), 8'h3);
        chk("beq1_src", 8'(bus.PC_src), 8'h1);
        chk("beq1_pcw", 8'(bus.PC_write), 8'h1);
        tick;
        chk("beq1_back", bus.state, ST_FETCH);

        // BEQ not taken
        bus.Beq_alu = 1'b0;
        tick;
        tick;
        chk("beq0_alu", 8'(bus.ALU_selection), 8'h3);
        chk("beq0_src", 8'(bus.PC_src), 8'h1);
        chk("beq0_pcw", 8'(bus.PC_write), 8'h0);
        tick;

        // J
        bus.opcode = 6'b010011;
        tick;
        tick;
        chk("j_st", bus.state, ST_JUMP);
        chk("j_src", 8'(bus.PC_src), 8'h2);
        chk("j_pcw", 8'(bus.PC_write), 8'h1);
        tick;
        chk("j_back", bus.state, ST_FETCH);

        // Illegal ALU nibble
        bus.opcode = 6'b000110;
        tick;
        chk("ill1_pulse", 8'(bus.illegal_op), 8'h1);
        tick;
        chk("ill1_st", bus.state, ST_FETCH);
        chk("ill1_clr", 8'(bus.illegal_op), 8'h0);
        chk("ill1_rw", 8'(bus.Reg_write), 8'h0);

        // Illegal 11xxxx class
        bus.opcode = 6'b110000;
        tick;
        chk("ill2_pulse", 8'(bus.illegal_op), 8'h1);
        tick;
        chk("ill2_st", bus.state, ST_FETCH);
        chk("ill2_clr", 8'(bus.illegal_op), 8'h0);

        // Fetch timeout with MAX_WAIT=4
        bus.mem_ready = 1'b0;
        #1;
        chk("tmo_c1_irw", 8'(bus.IR_write), 8'h0);
        tick;
        tick;
        tick;
        chk("tmo_c4_st", bus.state, ST_FETCH);
        chk("tmo_c4_flag", 8'(bus.mem_timeout), 8'h0);
        chk("tmo_c4_pcw", 8'(bus.PC_write), 8'h0);
        tick;
        chk("tmo_set", 8'(bus.mem_timeout), 8'h1);
        chk("tmo_st", bus.state, ST_FETCH);
        tick;
        chk("tmo_sticky", 8'(bus.mem_timeout), 8'h1);

        // SW, then reset in the middle of the write
        bus.opcode    = 6'b010001;
        bus.mem_ready = 1'b1;
        tick;
        tick;
        bus.mem_ready = 1'b0;
        tick;
        chk("sw_st", bus.state, ST_MWR);
        chk("sw_mw", 8'(bus.Mem_write), 8'h1);
        chk("sw_mr", 8'(bus.Mem_read), 8'h0);
        chk("sw_iord", 8'(bus.IorD), 8'h1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_mw", 8'(bus.Mem_write), 8'h0);
        chk("arst_st", bus.state, ST_RST);
        chk("arst_tmo", 8'(bus.mem_timeout), 8'h0);
        all_idle("arst");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        bus.mem_ready = 1'b1;
        tick;
        chk("post_st", bus.state, ST_FETCH);
        chk("post_tmo", 8'(bus.mem_timeout), 8'h0);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
